alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_rr_arb.sv | 10 +
 rtl/alu_arbiter.sv | 100 ++++++++++
 tb/tb_alu_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state encoding and default multiply latency shared by the ALU arbiter
package alu_pkg;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_MUL = 2'b10;
    localparam logic [1:0] ALU_ROR = 2'b11;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int MUL_CYCLES_DEF = 2;
endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: two-way grant; on contention the requester other than last_grant wins
// ports: valid0/valid1 request valids, last_grant previous winner, grant winning index
module alu_rr_arb (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant
);
    assign grant = (valid0 && valid1) ? ~last_grant : valid1;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters (IDLE/EXEC/RESP FSM)
// ports: clk/reset (sync, active-high); reqN{Valid,Ready,In1,In2,Op} request channels;
//        rspN{Valid,Ready} response channels sharing rspData; aluIn1/aluIn2/aluOp/aluOut ALU link; busy
// ALU_ARBITER_RR_EN defined: round-robin on contention; undefined: requester 0 always wins
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0Valid,
    input  logic        req1Valid,
    output logic        req0Ready,
    output logic        req1Ready,
    input  logic [31:0] req0In1,
    input  logic [31:0] req0In2,
    input  logic [31:0] req1In1,
    input  logic [31:0] req1In2,
    input  logic [1:0]  req0Op,
    input  logic [1:0]  req1Op,
    output logic        rsp0Valid,
    output logic        rsp1Valid,
    input  logic        rsp0Ready,
    input  logic        rsp1Ready,
    output logic [31:0] rspData,
    output logic [31:0] aluIn1,
    output logic [31:0] aluIn2,
    output logic [1:0]  aluOp,
    input  logic [31:0] aluOut,
    output logic        busy
);
    state_t      state;
    logic [2:0]  cnt;
    logic        owner;
    logic        grant;
    logic        last_grant;
    logic        accept;
    logic [1:0]  sel_op;

    alu_rr_arb u_arb (
        .valid0     (req0Valid),
        .valid1     (req1Valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0Ready = (state == IDLE) && !grant && req0Valid;
    assign req1Ready = (state == IDLE) && grant && req1Valid;
    assign accept    = req0Ready || req1Ready;
    assign sel_op    = grant ? req1Op : req0Op;
    assign rsp0Valid = (state == RESP) && !owner;
    assign rsp1Valid = (state == RESP) && owner;
    assign busy      = state != IDLE;

`ifdef ALU_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant;
    end
`else
    // tied high so contention always resolves to requester 0
    assign last_grant = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            owner   <= 1'b0;
            aluIn1  <= '0;
            aluIn2  <= '0;
            aluOp   <= '0;
            rspData <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    aluIn1 <= grant ? req1In1 : req0In1;
                    aluIn2 <= grant ? req1In2 : req0In2;
                    aluOp  <= sel_op;
                    owner  <= grant;
                    cnt    <= (sel_op == ALU_MUL) ? 3'(MUL_CYCLES) : 3'd1;
                    state  <= EXEC;
                end
                EXEC: if (cnt == 3'd1) begin
                    rspData <= aluOut;
                    cnt     <= '0;
                    state   <= RESP;
                end else begin
                    cnt <= cnt - 3'd1;
                end
                RESP: if (owner ? rsp1Ready : rsp0Ready)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU on the ALU port
module tb_alu_arbiter;
    import alu_pkg::*;
`ifdef ALU_ARBITER_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic req0Valid = 0, req1Valid = 0, rsp0Ready = 0, rsp1Ready = 0;
    logic [31:0] req0In1 = 0, req0In2 = 0, req1In1 = 0, req1In2 = 0;
    logic [1:0] req0Op = 0, req1Op = 0;
    logic req0Ready, req1Ready, rsp0Valid, rsp1Valid, busy;
    logic [31:0] rspData, aluIn1, aluIn2, aluOut;
    logic [1:0] aluOp;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    always_comb
        aluOut = (aluOp == ALU_ADD) ? aluIn1 + aluIn2 :
                 (aluOp == ALU_SUB) ? aluIn2 - aluIn1 :
                 (aluOp == ALU_MUL) ? aluIn1 * aluIn2 :
                 (aluIn2 >> aluIn1[4:0]) | (aluIn2 << (6'd32 - {1'b0, aluIn1[4:0]}));

    alu_arbiter #(.MUL_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req0Valid(req0Valid), .req1Valid(req1Valid),
        .req0Ready(req0Ready), .req1Ready(req1Ready),
        .req0In1(req0In1), .req0In2(req0In2), .req1In1(req1In1), .req1In2(req1In2),
        .req0Op(req0Op), .req1Op(req1Op),
        .rsp0Valid(rsp0Valid), .rsp1Valid(rsp1Valid),
        .rsp0Ready(rsp0Ready), .rsp1Ready(rsp1Ready),
        .rspData(rspData), .aluIn1(aluIn1), .aluIn2(aluIn2), .aluOp(aluOp),
        .aluOut(aluOut), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_busy", busy, 0);
        chk("rst_rsp0", rsp0Valid, 0);
        chk("rst_rsp1", rsp1Valid, 0);
        chk("rst_data", rspData, 0);
        chk("rst_alu1", aluIn1, 0);
        chk("rst_op", aluOp, 0);
        reset = 0;
        cyc();
        chk("idle_busy", busy, 0);
        // req0 ADD 5+7
        req0Valid = 1; req0In1 = 5; req0In2 = 7; req0Op = ALU_ADD;
        #1;
        chk("add_rdy0", req0Ready, 1);
        chk("add_rdy1", req1Ready, 0);
        cyc();
        req0Valid = 0;
        chk("add_busy", busy, 1);
        chk("add_t1_rsp0", rsp0Valid, 0);
        chk("add_t1_in1", aluIn1, 5);
        chk("add_t1_in2", aluIn2, 7);
        cyc();
        chk("add_t2_rsp0", rsp0Valid, 1);
        chk("add_t2_rsp1", rsp1Valid, 0);
        chk("add_data", rspData, 12);
        rsp0Ready = 1;
        cyc();
        rsp0Ready = 0;
        chk("add_done", busy, 0);
        chk("add_done_rsp0", rsp0Valid, 0);
        // req0 ROR F1 by 4, then stall the response
        req0Valid = 1; req0In1 = 4; req0In2 = 32'h000000F1; req0Op = ALU_ROR;
        cyc();
        req0Valid = 0;
        cyc();
        chk("ror_data", rspData, 32'h1000000F);
        req1Valid = 1; req1In1 = 0; req1In2 = 0; req1Op = ALU_ADD;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ror_hold_v", rsp0Valid, 1);
            chk("ror_hold_d", rspData, 32'h1000000F);
            chk("ror_hold_busy", busy, 1);
            chk("ror_hold_rdy1", req1Ready, 0);
            cyc();
        end
        rsp0Ready = 1;
        cyc();
        rsp0Ready = 0;
        chk("ror_idle_rdy1", req1Ready, 1);
        req1Valid = 0;
        cyc();
        chk("withdraw_busy", busy, 0);
        // req1 MUL 6*7
        req1Valid = 1; req1In1 = 6; req1In2 = 7; req1Op = ALU_MUL;
        #1;
        chk("mul_rdy1", req1Ready, 1);
        cyc();
        req1Valid = 0; req1In1 = 0; req1In2 = 0; req1Op = ALU_ADD;
        for (int i = 0; i < 2; i++) begin
            chk("mul_in1", aluIn1, 6);
            chk("mul_in2", aluIn2, 7);
            chk("mul_op", aluOp, ALU_MUL);
            chk("mul_rsp_early", rsp1Valid, 0);
            cyc();
        end
        chk("mul_rsp1", rsp1Valid, 1);
        chk("mul_rsp0", rsp0Valid, 0);
        chk("mul_data", rspData, 42);
        rsp1Ready = 1;
        cyc();
        rsp1Ready = 0;
        chk("mul_done", busy, 0);
        // contention: req0 SUB 10-3 vs req1 ADD 1+1, both held valid
        req0Valid = 1; req0In1 = 3; req0In2 = 10; req0Op = ALU_SUB;
        req1Valid = 1; req1In1 = 1; req1In2 = 1; req1Op = ALU_ADD;
        #1;
        chk("both_rdy0", req0Ready, 1);
        chk("both_rdy1", req1Ready, 0);
        cyc();
        chk("both_exec_rdy1", req1Ready, 0);
        cyc();
        chk("sub_rsp0", rsp0Valid, 1);
        chk("sub_data", rspData, 7);
        chk("sub_rdy1", req1Ready, 0);
        rsp0Ready = 1;
        cyc();
        rsp0Ready = 0;
        chk("both_again_rdy1", req1Ready, RR);
        chk("both_again_rdy0", req0Ready, !RR);
        req0Valid = 0;
        #1;
        chk("solo_rdy1", req1Ready, 1);
        cyc();
        req1Valid = 0;
        cyc();
        chk("add1_rsp1", rsp1Valid, 1);
        chk("add1_data", rspData, 2);
        rsp1Ready = 1;
        cyc();
        rsp1Ready = 0;
        // reset during EXEC aborts the multiply
        req0Valid = 1; req0In1 = 2; req0In2 = 3; req0Op = ALU_MUL;
        cyc();
        req0Valid = 0;
        chk("abort_busy", busy, 1);
        reset = 1;
        cyc();
        reset = 0;
        chk("abort_idle", busy, 0);
        chk("abort_data", rspData, 0);
        chk("abort_alu1", aluIn1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("abort_rsp0", rsp0Valid, 0);
            chk("abort_rsp1", rsp1Valid, 0);
            cyc();
        end
        req0Valid = 1; req0In1 = 2; req0In2 = 2; req0Op = ALU_ADD;
        req1Valid = 1; req1In1 = 9; req1In2 = 9; req1Op = ALU_ADD;
        #1;
        chk("post_rst_rdy0", req0Ready, 1);
        chk("post_rst_rdy1", req1Ready, 0);
        cyc();
        req0Valid = 0; req1Valid = 0;
        cyc();
        chk("post_rst_rsp0", rsp0Valid, 1);
        chk("post_rst_data", rspData, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
